// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic ARB_OWN_I = 1'b0;
  localparam logic ARB_OWN_D = 1'b1;

  localparam int ARB_MEM_LATENCY = 4;
  localparam int ARB_CNT_W       = 4;

  // Contended requests go to the port that did not win last time.
  function automatic logic arb_rr_pick(input logic i_req, input logic d_req, input logic last_grant);
    if (i_req && d_req) begin
      return ~last_grant;
    end
    return d_req ? ARB_OWN_D : ARB_OWN_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side signals of the port arbiter; slave = arbiter view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports over a fixed latency.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise data always wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = ARB_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);
  localparam logic [ARB_CNT_W-1:0] CNT_INIT = ARB_CNT_W'(MEM_LATENCY - 1);

  arb_state_e           state_q, state_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
  logic                 i_ready_q, i_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic                 grant_owner;
  logic                 any_req;

  assign any_req = bus.i_req | bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  assign grant_owner = arb_rr_pick(bus.i_req, bus.d_req, last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ARB_IDLE && any_req) begin
      last_grant_d = grant_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= ARB_OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // The MEM-stage instruction is older than the one being fetched, so it goes first.
  assign grant_owner = bus.d_req ? ARB_OWN_D : ARB_OWN_I;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = grant_owner;
          addr_d  = (grant_owner == ARB_OWN_D) ? bus.d_addr : bus.i_addr;
          we_d    = (grant_owner == ARB_OWN_D) & bus.d_we;
          wdata_d = (grant_owner == ARB_OWN_D) ? bus.d_wdata : '0;
          cnt_d   = CNT_INIT;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cnt_q == '0) begin
          // Final busy cycle: memory data is valid now, ready pulses from RESP.
          if (!we_q) begin
            if (owner_q == ARB_OWN_D) d_rdata_d = bus.mem_rdata;
            else                      i_rdata_d = bus.mem_rdata;
          end
          d_ready_d = (owner_q == ARB_OWN_D);
          i_ready_d = (owner_q == ARB_OWN_I);
          state_d   = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      owner_q   <= ARB_OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
    end
  end

  assign bus.mem_read  = (state_q == ARB_BUSY) & ~we_q;
  assign bus.mem_write = (state_q == ARB_BUSY) & we_q & (cnt_q == '0);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.i_ready = i_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_stall = bus.i_req & ~i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_stall = bus.d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: latency-4 instance plus a latency-1 instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_load = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];

  function automatic logic [15:0] seed0(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hABCD;
      8'h30:   return 16'h5555;
      8'h40:   return 16'h6666;
      8'h50:   return 16'h1111;
      default: return {a, ~a};
    endcase
  endfunction

  function automatic logic [15:0] seed1(input logic [7:0] a);
    case (a)
      8'h00:   return 16'hA0A0;
      8'h01:   return 16'h0B0B;
      default: return {~a, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 256; k++) begin
        mem0[k] <= seed0(8'(k));
        mem1[k] <= seed1(8'(k));
      end
    end else begin
      if (bus.mem_write)  mem0[bus.mem_addr[7:0]]  <= bus.mem_wdata;
      if (bus1.mem_write) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
  end

  assign bus.mem_rdata  = mem0[bus.mem_addr[7:0]];
  assign bus1.mem_rdata = mem1[bus1.mem_addr[7:0]];

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_d_rdata = 16'h0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sb_empty(input string name);
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL %s_sb_left: got %0d pending expectations, expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
    tick();
    n_vec++;
    if ({bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b expected 0000", {bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write});
    end
    n_vec++;
    if (bus.i_rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_i_rdata: got %h expected 0000", bus.i_rdata);
    end
    n_vec++;
    if (bus.d_rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_d_rdata: got %h expected 0000", bus.d_rdata);
    end
    n_vec++;
    if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0000 0000", bus.mem_addr, bus.mem_wdata);
    end
    n_vec++;
    if ({bus.i_stall, bus.d_stall} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_stalls: got %b expected 00", {bus.i_stall, bus.d_stall});
    end
    n_vec++;
    if ({bus1.i_ready, bus1.mem_read, bus1.mem_write, bus1.i_rdata} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_lat1: got %h expected 0", {bus1.i_ready, bus1.mem_read, bus1.mem_write, bus1.i_rdata});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    exp_t e;
    bus.i_addr = 16'h0010;
    bus.i_req  = 1'b1;
    sb.push_back(exp_t'{port: ARB_OWN_I, data: 16'hABCD});
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        n_vec++;
        if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 16'h0010) begin
          n_err++;
          $display("FAIL fetch_busy[%0d]: got rd %b wr %b addr %h expected 1 0 0010", k, bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        n_vec++;
        if (bus.i_ready !== 1'b0 || bus.i_stall !== 1'b1) begin
          n_err++;
          $display("FAIL fetch_stall[%0d]: got ready %b stall %b expected 0 1", k, bus.i_ready, bus.i_stall);
        end
      end else begin
        n_vec++;
        if (bus.i_ready !== 1'b1 || bus.i_stall !== 1'b0 || bus.mem_read !== 1'b0) begin
          n_err++;
          $display("FAIL fetch_ready: got ready %b stall %b rd %b expected 1 0 0", bus.i_ready, bus.i_stall, bus.mem_read);
        end
        if (bus.i_ready === 1'b1) begin
          e = sb.pop_front();
          n_vec++;
          if (bus.i_rdata !== e.data) begin
            n_err++;
            $display("FAIL fetch_data: got %h expected %h", bus.i_rdata, e.data);
          end
        end
      end
    end
    bus.i_req = 1'b0;
    tick();
    n_vec++;
    if (bus.i_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_pulse_width: got i_ready %b expected 0", bus.i_ready);
    end
    check_sb_empty("fetch");
  endtask

  task automatic test_write_read();
    exp_t e;
    int   wr_cnt;
    int   lat;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0020;
    bus.d_wdata = 16'h1234;
    sb.push_back(exp_t'{port: ARB_OWN_D, data: exp_d_rdata});
    wr_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (bus.mem_write === 1'b1) wr_cnt++;
      n_vec++;
      if (bus.mem_write !== (k == 4) || bus.mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL write_strobe[%0d]: got wr %b rd %b expected %b 0", k, bus.mem_write, bus.mem_read, (k == 4));
      end
      if (k == 4) begin
        n_vec++;
        if (bus.mem_addr !== 16'h0020 || bus.mem_wdata !== 16'h1234) begin
          n_err++;
          $display("FAIL write_bus: got addr %h wdata %h expected 0020 1234", bus.mem_addr, bus.mem_wdata);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (bus.d_ready !== 1'b1) begin
          n_err++;
          $display("FAIL write_ready: got d_ready %b expected 1", bus.d_ready);
        end else begin
          e = sb.pop_front();
          n_vec++;
          if (bus.d_rdata !== e.data) begin
            n_err++;
            $display("FAIL write_keeps_rdata: got %h expected %h", bus.d_rdata, e.data);
          end
        end
      end
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    n_vec++;
    if (wr_cnt !== 1 || mem0[8'h20] !== 16'h1234) begin
      n_err++;
      $display("FAIL write_commit: got %0d strobes word %h expected 1 1234", wr_cnt, mem0[8'h20]);
    end
    bus.d_addr = 16'h0020;
    bus.d_req  = 1'b1;
    sb.push_back(exp_t'{port: ARB_OWN_D, data: 16'h1234});
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      tick();
      if (bus.d_ready === 1'b1) begin
        lat = c;
        e = sb.pop_front();
        n_vec++;
        if (bus.d_rdata !== e.data) begin
          n_err++;
          $display("FAIL readback_data: got %h expected %h", bus.d_rdata, e.data);
        end
        bus.d_req = 1'b0;
      end
    end
    n_vec++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL readback_latency: got %0d cycles expected 5", lat);
    end
    exp_d_rdata = 16'h1234;
    bus.d_req = 1'b0;
    tick();
    check_sb_empty("write_read");
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic port;
    logic [15:0] data;
    int   t_first;
    int   t_second;
    bus.i_addr = 16'h0030;
    bus.d_addr = 16'h0040;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    sb.push_back(exp_t'{port: ARB_OWN_I, data: 16'h5555});
    sb.push_back(exp_t'{port: ARB_OWN_D, data: 16'h6666});
`else
    sb.push_back(exp_t'{port: ARB_OWN_D, data: 16'h6666});
    sb.push_back(exp_t'{port: ARB_OWN_I, data: 16'h5555});
`endif
    t_first  = -1;
    t_second = -1;
    for (int c = 1; c <= 30 && t_second < 0; c++) begin
      tick();
      if (c == 1) begin
        n_vec++;
        if ({bus.i_stall, bus.d_stall} !== 2'b11) begin
          n_err++;
          $display("FAIL sim_stalls: got %b expected 11", {bus.i_stall, bus.d_stall});
        end
      end
      if (bus.i_ready === 1'b1 || bus.d_ready === 1'b1) begin
        n_vec++;
        if (bus.i_ready === 1'b1 && bus.d_ready === 1'b1) begin
          n_err++;
          $display("FAIL sim_both_ready: got 11 expected one-hot");
        end
        port = bus.d_ready;
        data = port ? bus.d_rdata : bus.i_rdata;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sim_extra_ready: got port %b expected none", port);
        end else begin
          e = sb.pop_front();
          n_vec++;
          if (port !== e.port || data !== e.data) begin
            n_err++;
            $display("FAIL sim_order: got port %b data %h expected port %b data %h", port, data, e.port, e.data);
          end
        end
        if (t_first < 0) t_first = c;
        else             t_second = c;
        if (port) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
      end
    end
    n_vec++;
    if (t_first !== 5) begin
      n_err++;
      $display("FAIL sim_first_latency: got %0d expected 5", t_first);
    end
    n_vec++;
    if (t_second - t_first !== 6) begin
      n_err++;
      $display("FAIL sim_gap: got %0d cycles expected 6", t_second - t_first);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    exp_d_rdata = 16'h6666;
    tick();
    check_sb_empty("simultaneous");
  endtask

  task automatic test_hold_through_resp();
    exp_t e;
    int   npulse;
    int   consec;
    int   t1;
    int   t2;
    logic prev;
    bus.i_addr = 16'h0010;
    bus.i_req  = 1'b1;
    sb.push_back(exp_t'{port: ARB_OWN_I, data: 16'hABCD});
    sb.push_back(exp_t'{port: ARB_OWN_I, data: 16'hABCD});
    npulse = 0;
    consec = 0;
    t1 = -1;
    t2 = -1;
    prev = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.i_ready === 1'b1) begin
        npulse++;
        if (prev) consec++;
        if (t1 < 0) t1 = c;
        else        t2 = c;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_vec++;
          if (bus.i_rdata !== e.data) begin
            n_err++;
            $display("FAIL hold_data: got %h expected %h", bus.i_rdata, e.data);
          end
        end
      end
      prev = bus.i_ready;
    end
    bus.i_req = 1'b0;
    n_vec++;
    if (npulse !== 2 || consec !== 0) begin
      n_err++;
      $display("FAIL hold_pulses: got %0d pulses %0d back-to-back expected 2 0", npulse, consec);
    end
    n_vec++;
    if (t1 !== 5 || t2 !== 11) begin
      n_err++;
      $display("FAIL hold_timing: got ready at %0d,%0d expected 5,11", t1, t2);
    end
    tick();
    tick();
    check_sb_empty("hold");
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    logic wr_seen;
    logic rdy_seen;
    int   lat;
    wr_seen = 1'b0;
    rdy_seen = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0050;
    bus.d_wdata = 16'hBEEF;
    tick();
    if (bus.mem_write === 1'b1) wr_seen = 1'b1;
    tick();
    if (bus.mem_write === 1'b1) wr_seen = 1'b1;
    reset_n   = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    n_vec++;
    if ({bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 68'h0) begin
      n_err++;
      $display("FAIL abort_outputs: got rdy %b%b rd %b wr %b addr %h wdata %h ird %h drd %h expected all 0",
               bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
    end
    reset_n = 1'b1;
    exp_d_rdata = 16'h0000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.d_ready === 1'b1 || bus.i_ready === 1'b1) rdy_seen = 1'b1;
      if (bus.mem_write === 1'b1) wr_seen = 1'b1;
    end
    n_vec++;
    if (wr_seen !== 1'b0 || rdy_seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_strobe: got write %b ready %b expected 0 0", wr_seen, rdy_seen);
    end
    n_vec++;
    if (mem0[8'h50] !== 16'h1111) begin
      n_err++;
      $display("FAIL abort_mem_intact: got %h expected 1111", mem0[8'h50]);
    end
    bus.d_addr = 16'h0050;
    bus.d_req  = 1'b1;
    sb.push_back(exp_t'{port: ARB_OWN_D, data: 16'h1111});
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      tick();
      if (bus.d_ready === 1'b1) begin
        lat = c;
        e = sb.pop_front();
        n_vec++;
        if (bus.d_rdata !== e.data) begin
          n_err++;
          $display("FAIL abort_recover_data: got %h expected %h", bus.d_rdata, e.data);
        end
        bus.d_req = 1'b0;
      end
    end
    n_vec++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL abort_recover_latency: got %0d expected 5", lat);
    end
    bus.d_req = 1'b0;
    exp_d_rdata = 16'h1111;
    tick();
    check_sb_empty("abort");
  endtask

  task automatic test_back_to_back_lat1();
    exp_t e;
    int   npulse;
    int   t1;
    int   t2;
    bus1.i_addr = 16'h0000;
    bus1.i_req  = 1'b1;
    sb.push_back(exp_t'{port: ARB_OWN_I, data: 16'hA0A0});
    sb.push_back(exp_t'{port: ARB_OWN_I, data: 16'h0B0B});
    npulse = 0;
    t1 = -1;
    t2 = -1;
    for (int c = 1; c <= 12 && npulse < 2; c++) begin
      tick();
      if (c == 1) begin
        n_vec++;
        if (bus1.mem_read !== 1'b1 || bus1.mem_addr !== 16'h0000) begin
          n_err++;
          $display("FAIL lat1_busy: got rd %b addr %h expected 1 0000", bus1.mem_read, bus1.mem_addr);
        end
      end
      if (bus1.i_ready === 1'b1) begin
        npulse++;
        e = sb.pop_front();
        n_vec++;
        if (bus1.i_rdata !== e.data) begin
          n_err++;
          $display("FAIL lat1_data[%0d]: got %h expected %h", npulse, bus1.i_rdata, e.data);
        end
        if (npulse == 1) begin
          t1 = c;
          bus1.i_addr = 16'h0001;
        end else begin
          t2 = c;
          bus1.i_req = 1'b0;
        end
      end
    end
    bus1.i_req = 1'b0;
    n_vec++;
    if (t1 !== 2 || t2 - t1 !== 3) begin
      n_err++;
      $display("FAIL lat1_spacing: got first %0d gap %0d expected 2 3", t1, t2 - t1);
    end
    tick();
    check_sb_empty("lat1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req    = 1'b0;
    bus.i_addr   = 16'h0000;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = 16'h0000;
    bus.d_wdata  = 16'h0000;
    bus1.i_req   = 1'b0;
    bus1.i_addr  = 16'h0000;
    bus1.d_req   = 1'b0;
    bus1.d_we    = 1'b0;
    bus1.d_addr  = 16'h0000;
    bus1.d_wdata = 16'h0000;

    test_reset();
    test_fetch();
    test_write_read();
    test_simultaneous();
    test_hold_through_resp();
    test_reset_mid_busy();
    test_back_to_back_lat1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
